// File: rtl/timer_array.sv
// -----------------------------------------------------------------------------
// timer_array
//
// Bank of NUM_CH independent up-counting timers. Each channel has a two-state
// FSM (IDLE/RUN). A start loads the channel's terminal value and mode, and
// the counter then advances once per tick. Each channel raises half_trigger
// at the midpoint of its period and trigger at the end of its period.
// One-shot channels return to IDLE on their first wrap. Periodic channels
// keep running until they are stopped.
//
// Optional feature (macro TIMER_ARRAY_PRESCALE_EN):
//   A shared prescaler divides clk by (presc + 1) to form the tick. Without
//   the macro, the presc port and the prescaler do not exist and every clk
//   is a tick.
//
// Parameters
//   NUM_CH       number of channels (1..16)
//   WIDTH        per-channel counter width (2..32)
//   PRESC_WIDTH  shared prescaler width (used only with the macro)
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   count         per-channel terminal value, channel i at [i*WIDTH +: WIDTH]
//   start         per-channel start/restart request
//   stop          per-channel stop request (wins over start)
//   oneshot       per-channel mode latched at start: 1 = one-shot
//   presc         prescale divisor minus one (macro only)
//   busy          channel is in RUN
//   half_trigger  one-clk pulse at period midpoint
//   trigger       one-clk pulse at period end
// -----------------------------------------------------------------------------
module timer_array #(
  parameter int NUM_CH      = 2,
  parameter int WIDTH       = 16,
  parameter int PRESC_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] count,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH-1:0]       oneshot,
`ifdef TIMER_ARRAY_PRESCALE_EN
  input  logic [PRESC_WIDTH-1:0]  presc,
`endif
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       half_trigger,
  output logic [NUM_CH-1:0]       trigger
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  if (NUM_CH < 1 || NUM_CH > 16 || WIDTH < 2 || WIDTH > 32 || PRESC_WIDTH < 1) begin : g_param_check
    $error("timer_array: parameter out of range");
  end

  logic [NUM_CH-1:0] run_vec;  // one bit per channel, set while in RUN
  logic              tick;

`ifdef TIMER_ARRAY_PRESCALE_EN
  logic [PRESC_WIDTH-1:0] pcnt_q;

  assign tick = (pcnt_q == presc);

  // The prescaler is parked at 0 whenever the whole bank is idle. A start
  // from all-idle therefore sees its first tick presc+1 clocks later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
    end else if (run_vec == '0) begin
      pcnt_q <= '0;
    end else if (tick) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + 1'b1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    state_t            state_q;
    logic [WIDTH-1:0]  cntr_q;
    logic [WIDTH-1:0]  per_q;
    logic              mode_q;
    logic              trig_q;
    logic              half_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        cntr_q  <= '0;
        per_q   <= '0;
        mode_q  <= 1'b0;
        trig_q  <= 1'b0;
        half_q  <= 1'b0;
      end else begin
        // Pulses last exactly one cycle unless re-asserted below.
        trig_q <= 1'b0;
        half_q <= 1'b0;
        if (stop[gi]) begin
          state_q <= IDLE;
          cntr_q  <= '0;
        end else if (start[gi]) begin
          // Start or restart: no pulse on this edge, even when running.
          per_q   <= count[gi*WIDTH +: WIDTH];
          mode_q  <= oneshot[gi];
          cntr_q  <= '0;
          state_q <= RUN;
        end else if (state_q == RUN && tick) begin
          half_q <= (cntr_q == (per_q >> 1));
          if (cntr_q == per_q) begin
            cntr_q <= '0;
            trig_q <= 1'b1;
            // One-shot drops busy in the same cycle that trigger rises.
            if (mode_q) begin
              state_q <= IDLE;
            end
          end else begin
            cntr_q <= cntr_q + 1'b1;
          end
        end
      end
    end

    assign run_vec[gi]      = (state_q == RUN);
    assign busy[gi]         = (state_q == RUN);
    assign trigger[gi]      = trig_q;
    assign half_trigger[gi] = half_q;
  end

endmodule

// File: tb/tb_timer_array.sv
module tb_timer_array;

  localparam int NCH = 2;
  localparam int W   = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NCH*W-1:0] count = '0;
  logic [NCH-1:0]  start = '0;
  logic [NCH-1:0]  stop = '0;
  logic [NCH-1:0]  oneshot = '0;
`ifdef TIMER_ARRAY_PRESCALE_EN
  logic [7:0]      presc = 8'd0;
`endif
  logic [NCH-1:0]  busy;
  logic [NCH-1:0]  half_trigger;
  logic [NCH-1:0]  trigger;

  timer_array #(.NUM_CH(NCH), .WIDTH(W), .PRESC_WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .count       (count),
    .start       (start),
    .stop        (stop),
    .oneshot     (oneshot),
`ifdef TIMER_ARRAY_PRESCALE_EN
    .presc       (presc),
`endif
    .busy        (busy),
    .half_trigger(half_trigger),
    .trigger     (trigger)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Directed check: one line per transaction.
  task automatic dchk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(name, act, exp);
    if (act === exp) $display("check %s value=%0h at %0t", name, act, $time);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: tracks ticks elapsed since each channel's start and
  // derives pulses from the period arithmetic (period = per + 1 ticks).
  // ---------------------------------------------------------------------------
  bit       m_run [NCH];
  bit       m_one [NCH];
  int       m_per [NCH];
  longint   m_n   [NCH];
  logic [NCH-1:0] m_busy = '0;
  logic [NCH-1:0] m_trig = '0;
  logic [NCH-1:0] m_half = '0;
  int       ph = 0;
  bit       m_tick;
  bit       m_all_idle;
  longint   m_p;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        m_run[i] = 1'b0; m_one[i] = 1'b0; m_per[i] = 0; m_n[i] = 0;
      end
      m_busy = '0; m_trig = '0; m_half = '0; ph = 0;
    end else begin
      m_all_idle = 1'b1;
      for (int i = 0; i < NCH; i++) if (m_run[i]) m_all_idle = 1'b0;
`ifdef TIMER_ARRAY_PRESCALE_EN
      m_tick = (ph == int'(presc));
`else
      m_tick = 1'b1;
`endif
      for (int i = 0; i < NCH; i++) begin
        m_trig[i] = 1'b0;
        m_half[i] = 1'b0;
        if (stop[i]) begin
          m_run[i] = 1'b0;
        end else if (start[i]) begin
          m_run[i] = 1'b1;
          m_per[i] = int'(count[i*W +: W]);
          m_one[i] = oneshot[i];
          m_n[i]   = 0;
        end else if (m_run[i] && m_tick) begin
          m_n[i] = m_n[i] + 1;
          m_p    = longint'(m_per[i]) + 1;
          if (((m_n[i] - 1) % m_p) == longint'(m_per[i] / 2)) m_half[i] = 1'b1;
          if ((m_n[i] % m_p) == 0) begin
            m_trig[i] = 1'b1;
            if (m_one[i]) m_run[i] = 1'b0;
          end
        end
        m_busy[i] = m_run[i];
      end
      if (m_all_idle) ph = 0;
      else if (m_tick) ph = 0;
      else ph = (ph + 1) % 256;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_busy", 32'(busy), 32'(m_busy));
      chk("cyc_trigger", 32'(trigger), 32'(m_trig));
      chk("cyc_half", 32'(half_trigger), 32'(m_half));
    end
  end

  initial begin
    // Reset
    step(); step();
    dchk("rst_busy", 32'(busy), 32'h0);
    dchk("rst_trigger", 32'(trigger), 32'h0);
    dchk("rst_half", 32'(half_trigger), 32'h0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    step();

`ifndef TIMER_ARRAY_PRESCALE_EN
    // ch0 count=4 periodic
    count[15:0] = 16'd4; oneshot = 2'b00; start = 2'b01;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 1) begin
        start = 2'b00;
        dchk("t1_busy_next", 32'(busy[0]), 32'h1);
      end
      dchk("t1_trig", 32'(trigger[0]), 32'((k == 6) || (k == 11) || (k == 16)));
      dchk("t1_half", 32'(half_trigger[0]), 32'((k == 4) || (k == 9) || (k == 14)));
    end
    stop = 2'b01; step(); stop = 2'b00;
    dchk("t1_stop_busy", 32'(busy[0]), 32'h0);

    // ch1 count=3 one-shot; later count/oneshot changes ignored
    count[31:16] = 16'd3; oneshot = 2'b10; start = 2'b10;
    for (int k = 1; k <= 25; k++) begin
      step();
      if (k == 1) begin
        start = 2'b00; oneshot = 2'b00; count[31:16] = 16'd1;
      end
      dchk("t2_trig", 32'(trigger[1]), 32'(k == 5));
      dchk("t2_half", 32'(half_trigger[1]), 32'(k == 3));
      dchk("t2_busy", 32'(busy[1]), 32'(k <= 4));
    end

    // ch0 count=0: pulses every cycle
    count[15:0] = 16'd0; start = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) start = 2'b00;
      dchk("t3_trig", 32'(trigger[0]), 32'(k >= 2));
      dchk("t3_half", 32'(half_trigger[0]), 32'(k >= 2));
    end
    stop = 2'b01; start = 2'b01; step(); stop = 2'b00; start = 2'b00;
    dchk("t3_stopstart_busy", 32'(busy[0]), 32'h0);
    dchk("t3_stopstart_trig", 32'(trigger[0]), 32'h0);

    // ch0 count=9, count change ignored, restart at cntr=7
    count[15:0] = 16'd9; start = 2'b01;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 1)  start = 2'b00;
      if (k == 6)  count[15:0] = 16'd2;
      if (k == 18) begin count[15:0] = 16'd9; start = 2'b01; end
      if (k == 19) start = 2'b00;
      dchk("t4_trig", 32'(trigger[0]), 32'((k == 11) || (k == 29)));
      dchk("t4_half", 32'(half_trigger[0]), 32'((k == 6) || (k == 16) || (k == 24)));
    end
    stop = 2'b01; step(); stop = 2'b00;

    // Reset mid-count (cntr=3 of count=7)
    count[15:0] = 16'd7; start = 2'b01;
    step(); start = 2'b00;
    step(); step(); step();
    dchk("t5_busy_before", 32'(busy[0]), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    dchk("t5_rst_busy", 32'(busy), 32'h0);
    dchk("t5_rst_trig", 32'(trigger), 32'h0);
    dchk("t5_rst_half", 32'(half_trigger), 32'h0);
    step(); rst_n = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k == 15) begin
        dchk("t5_after_busy", 32'(busy), 32'h0);
        dchk("t5_after_trig", 32'(trigger), 32'h0);
      end
    end

    // Both channels concurrently
    count = {16'd5, 16'd2}; oneshot = 2'b00; start = 2'b11;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 1) start = 2'b00;
      dchk("t6_trig0", 32'(trigger[0]), 32'((k == 4) || (k == 7) || (k == 10) || (k == 13)));
      dchk("t6_trig1", 32'(trigger[1]), 32'((k == 7) || (k == 13)));
    end
    stop = 2'b11; step(); stop = 2'b00;
`else
    // Shared prescaler presc=2: tick every 3 clks
    presc = 8'd2; count = {16'd4, 16'd1}; oneshot = 2'b00; start = 2'b11;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) start = 2'b00;
      dchk("t7_trig0", 32'(trigger[0]), 32'((k == 7) || (k == 13) || (k == 19)));
      dchk("t7_trig1", 32'(trigger[1]), 32'(k == 16));
    end
    stop = 2'b11; step(); stop = 2'b00;
    dchk("t7_stop_busy", 32'(busy), 32'h0);
`endif

    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
